// File: rtl/vedic_seq_mult6_if.sv
// Operand/product handshake bundle for vedic_seq_mult6, plus the FSM state debug tap.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready are both high;
// a source holds valid and its payload stable until that edge, and ready never depends on valid.
interface vedic_seq_mult6_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] p;
  logic        busy;
  logic [1:0]  dbg_state;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy, dbg_state
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy, dbg_state
  );
endinterface

// File: rtl/vedic_seq_mult6.sv
// Sequential 6x6 unsigned multiplier reusing one 3x3 core over four partial-product steps.
// Optional build macro VEDIC_ZERO_SKIP_EN: zero operands bypass MUL and finish in one edge.
module vedic_seq_mult6 (
  input  logic               clk,
  input  logic               rst,
  vedic_seq_mult6_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  a_q, b_q;
  logic [11:0] acc;
  logic [1:0]  step;
  logic [11:0] p_q;

  logic        accept;
  logic        zero_pair;
  logic [2:0]  core_x, core_y;
  logic [5:0]  pp;
  logic [3:0]  shamt;
  logic [11:0] pp_shifted;
  logic [11:0] acc_sum;

  assign accept = bus.in_valid && (state == IDLE);

`ifdef VEDIC_ZERO_SKIP_EN
  assign zero_pair = (bus.a == 6'd0) || (bus.b == 6'd0);
`else
  assign zero_pair = 1'b0;
`endif

  // step[0] selects the high half of a, step[1] the high half of b.
  assign core_x = step[0] ? a_q[5:3] : a_q[2:0];
  assign core_y = step[1] ? b_q[5:3] : b_q[2:0];
  assign pp     = {3'b000, core_x} * {3'b000, core_y};

  always_comb begin
    shamt = 4'd0;
    case (step)
      2'd0:    shamt = 4'd0;
      2'd1,
      2'd2:    shamt = 4'd3;
      default: shamt = 4'd6;
    endcase
  end

  assign pp_shifted = {6'b000000, pp} << shamt;
  assign acc_sum    = acc + pp_shifted;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = zero_pair ? DONE : MUL;
      end
      MUL: begin
        if (step == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= 6'd0;
      b_q   <= 6'd0;
      acc   <= 12'd0;
      step  <= 2'd0;
      p_q   <= 12'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            acc  <= 12'd0;
            step <= 2'd0;
            if (zero_pair) p_q <= 12'd0;
          end
        end
        MUL: begin
          acc  <= acc_sum;
          step <= step + 2'd1;
          if (step == 2'd3) p_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode the state register only.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == MUL);
  assign bus.p         = p_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_vedic_seq_mult6.sv
// Directed bench for vedic_seq_mult6: vector table, backpressure, mid-op reset.
module tb_vedic_seq_mult6;

  logic clk;
  logic rst;
  vedic_seq_mult6_if bus ();

  vedic_seq_mult6 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int exp_latency(input logic [5:0] a, input logic [5:0] b);
`ifdef VEDIC_ZERO_SKIP_EN
    if (a == 6'd0 || b == 6'd0) return 1;
`endif
    return 4;
  endfunction

  // driver: one full transaction; returns observed product, latency and busy cycles
  task automatic do_mult(input logic [5:0] a, input logic [5:0] b,
                         output logic [11:0] p, output int lat, output int busy_cnt,
                         output bit seen);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    p    = 12'd0;
    if (bus.out_valid) begin
      seen = 1'b1;
      lat  = 1;
    end
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) seen = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    if (seen && lat == 0) lat = 1;
    p = bus.p;
  endtask

  task automatic finish_handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_handshake", int'(bus.in_ready), 1);
    check("out_valid_after_handshake", int'(bus.out_valid), 0);
  endtask

  initial begin
    logic [11:0] got_p;
    int lat, bcnt, elat;
    bit seen;
    logic [11:0] exp_p;

    vecs[0] = '{a: 6'd7,  b: 6'd7,  p: 12'd49};
    vecs[1] = '{a: 6'd45, b: 6'd27, p: 12'd1215};
    vecs[2] = '{a: 6'd63, b: 6'd63, p: 12'd3969};
    vecs[3] = '{a: 6'd8,  b: 6'd1,  p: 12'd8};
    vecs[4] = '{a: 6'd0,  b: 6'd63, p: 12'd0};
    vecs[5] = '{a: 6'd63, b: 6'd0,  p: 12'd0};
    vecs[6] = '{a: 6'd1,  b: 6'd63, p: 12'd63};
    vecs[7] = '{a: 6'd36, b: 6'd9,  p: 12'd324};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 6'd0;
    bus.b         = 6'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_p", int'(bus.p), 0);
    check("reset_state", int'(bus.dbg_state), 0);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].p);
      elat = exp_latency(vecs[i].a, vecs[i].b);
      do_mult(vecs[i].a, vecs[i].b, got_p, lat, bcnt, seen);
      check($sformatf("vec%0d_out_valid_seen", i), int'(seen), 1);
      exp_p = exp_q.pop_front();
      check($sformatf("vec%0d_p", i), int'(got_p), int'(exp_p));
      check($sformatf("vec%0d_latency", i), lat, elat);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, (elat == 1) ? 0 : 4);
      if (seen) finish_handshake();
    end

    // backpressure: DONE held with out_ready low; input traffic ignored
    exp_q.push_back(12'd30);
    do_mult(6'd5, 6'd6, got_p, lat, bcnt, seen);
    exp_p = exp_q.pop_front();
    check("bp_p", int'(got_p), int'(exp_p));
    bus.in_valid = 1'b1;
    bus.a        = 6'd9;
    bus.b        = 6'd9;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_out_valid", k), int'(bus.out_valid), 1);
      check($sformatf("bp_hold%0d_p", k), int'(bus.p), 30);
      check($sformatf("bp_hold%0d_in_ready", k), int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    finish_handshake();

    // reset mid-operation at step 2
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 6'd63;
    bus.b        = 6'd63;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_state", int'(bus.dbg_state), 0);
    check("midrst_p", int'(bus.p), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    exp_q.push_back(12'd6);
    do_mult(6'd2, 6'd3, got_p, lat, bcnt, seen);
    exp_p = exp_q.pop_front();
    check("post_rst_p", int'(got_p), int'(exp_p));
    check("post_rst_latency", lat, 4);
    if (seen) finish_handshake();

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
